// File: rtl/vga_scan_out_if.sv
// vga_scan_out_if: pixel request/return path between the scan-out stage and the frame store.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 12
`endif

interface vga_scan_out_if #(parameter int PIXEL_SIZE = `PIXEL_SIZE);
  logic [PIXEL_SIZE-1:0] pix_in;
  logic [10:0] x_req;
  logic [9:0] y_req;
  logic req_valid;
  modport master (output x_req, y_req, req_valid, input pix_in);
  modport slave (input x_req, y_req, req_valid, output pix_in);
endinterface

// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA timing generator that fetches pixels from the frame store and drives aligned sync/de/rgb pins.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 12
`endif

module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int PIXEL_SIZE = `PIXEL_SIZE,
  parameter int CLK_DIV = 2,
  parameter int FETCH_LAT = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic resetn,
  vga_scan_out_if.master fs,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic [PIXEL_SIZE-1:0] rgb,
  output logic line_start,
  output logic frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [10:0] h_cnt;
  logic [9:0] v_cnt;
  logic tick, h_last, v_last, active, hs_raw, vs_raw;
  logic [FETCH_LAT-1:0] act_d, hs_d, vs_d;
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign h_last = h_cnt == 11'(H_TOTAL - 1);
  assign v_last = v_cnt == 10'(V_TOTAL - 1);
  assign active = h_cnt < 11'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
  assign hs_raw = h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC);
  // Strobes are gated by resetn so a CLK_DIV=1 tick cannot leak out while held in reset.
  assign line_start = resetn && tick && h_cnt == '0;
  assign frame_start = line_start && v_cnt == '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  // Region flags ride a FETCH_LAT-deep delay line so sync/de stay aligned with returned pixels.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fs.x_req <= '0;
      fs.y_req <= '0;
      fs.req_valid <= 1'b0;
      act_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      de <= 1'b0;
      rgb <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (tick) begin
      fs.req_valid <= active;
      if (active) begin
        fs.x_req <= h_cnt;
        fs.y_req <= v_cnt;
      end
      act_d <= FETCH_LAT'({act_d, active});
      hs_d <= FETCH_LAT'({hs_d, hs_raw});
      vs_d <= FETCH_LAT'({vs_d, vs_raw});
      de <= act_d[FETCH_LAT-1];
      rgb <= act_d[FETCH_LAT-1] ? fs.pix_in : '0;
      hsync <= hs_d[FETCH_LAT-1] ~^ SYNC_POL;
      vsync <= vs_d[FETCH_LAT-1] ~^ SYNC_POL;
    end
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: two scan-out instances (CLK_DIV=1/FETCH_LAT=1 and CLK_DIV=2/FETCH_LAT=2/active-high sync)
// compared cycle by cycle against a tick-position reference model.
module tb_vga_scan_out;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;
  typedef struct packed {
    logic de, hs, vs, ls, frm, rv;
    logic [11:0] rgb;
    logic [10:0] x;
    logic [9:0] y;
  } vo_t;
  logic clk = 1'b0;
  logic rstn_a = 1'b0, rstn_b = 1'b0;
  bit ones = 1'b0;
  int checks = 0, errors = 0;
  int e_a = 0, e_b = 0;
  logic de_a, hs_a, vs_a, ls_a, fs_a, de_b, hs_b, vs_b, ls_b, fs_b;
  logic [11:0] rgb_a, rgb_b, pix_b;
  vo_t pins_a, pins_b;
  always #5 clk = ~clk;
  vga_scan_out_if #(.PIXEL_SIZE(12)) fa ();
  vga_scan_out_if #(.PIXEL_SIZE(12)) fb ();
  vga_scan_out #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .PIXEL_SIZE(12), .CLK_DIV(1), .FETCH_LAT(1), .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .resetn(rstn_a), .fs(fa), .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a),
    .line_start(ls_a), .frame_start(fs_a));
  vga_scan_out #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .PIXEL_SIZE(12), .CLK_DIV(2), .FETCH_LAT(2), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .resetn(rstn_b), .fs(fb), .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b),
    .line_start(ls_b), .frame_start(fs_b));
  // Frame store models: zero-latency for FETCH_LAT=1, one registered tick for FETCH_LAT=2.
  assign fa.pix_in = ones ? 12'hFFF : {fa.y_req[5:0], fa.x_req[5:0]};
  assign fb.pix_in = pix_b;
  always @(posedge clk) if (rstn_b && e_b % 2 == 1) pix_b <= ones ? 12'hFFF : {fb.y_req[5:0], fb.x_req[5:0]};
  always @(posedge clk) begin
    e_a <= rstn_a ? e_a + 1 : 0;
    e_b <= rstn_b ? e_b + 1 : 0;
  end
  assign pins_a = {de_a, hs_a, vs_a, ls_a, fs_a, fa.req_valid, rgb_a, fa.x_req, fa.y_req};
  assign pins_b = {de_b, hs_b, vs_b, ls_b, fs_b, fb.req_valid, rgb_b, fb.x_req, fb.y_req};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic vo_t idle(input bit pol);
    vo_t r;
    r = '0;
    r.hs = ~pol;
    r.vs = ~pol;
    return r;
  endfunction

  // e = clk edges since reset release; n = ticks elapsed; pins show position n-fl-1, requests n-1.
  function automatic vo_t model(input int e, input int d, input int fl, input bit pol, input bit on);
    vo_t r;
    int n, p, q, h, v;
    logic [11:0] c;
    r = idle(pol);
    n = e / d;
    p = n - fl - 1;
    if (p >= 0) begin
      h = p % HT;
      v = (p / HT) % VT;
      r.de = h < HA && v < VA;
      if (h >= HA + HFP && h < HA + HFP + HS) r.hs = pol;
      if (v >= VA + VFP && v < VA + VFP + VS) r.vs = pol;
      c = {v[5:0], h[5:0]};
      r.rgb = !r.de ? 12'h000 : on ? 12'hFFF : c;
    end
    q = n - 1;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      r.rv = h < HA && v < VA;
      if (v >= VA) begin
        h = HA - 1;
        v = VA - 1;
      end else if (h >= HA) h = HA - 1;
      r.x = 11'(h);
      r.y = 10'(v);
    end
    r.ls = (e % d == d - 1) && n % HT == 0;
    r.frm = r.ls && n % FR == 0;
    return r;
  endfunction

  task automatic cmp(input string t, input vo_t g, input vo_t x);
    check({t, "_de"}, g.de, x.de);
    check({t, "_hsync"}, g.hs, x.hs);
    check({t, "_vsync"}, g.vs, x.vs);
    check({t, "_line_start"}, g.ls, x.ls);
    check({t, "_frame_start"}, g.frm, x.frm);
    check({t, "_req_valid"}, g.rv, x.rv);
    check({t, "_rgb"}, g.rgb, x.rgb);
    check({t, "_x_req"}, g.x, x.x);
    check({t, "_y_req"}, g.y, x.y);
  endtask

  always @(negedge clk) begin
    cmp("a", pins_a, rstn_a ? model(e_a, 1, 1, 1'b0, ones) : idle(1'b0));
    cmp("b", pins_b, rstn_b ? model(e_b, 2, 2, 1'b1, ones) : idle(1'b1));
    if (rstn_a && !ones && e_a >= 2 && (e_a - 2) % HT == 5 && ((e_a - 2) / HT) % VT == 3)
      check("px53", rgb_a, 12'h0C5);
  end

  int a_de, a_hs, a_vs, a_ls, a_last, b_last;
  bit a_go, a_have, b_have;
  always @(negedge clk)
    if (!rstn_a) begin
      a_go = 0;
      a_have = 0;
    end else begin
      if (fs_a) begin
        if (a_go) begin
          check("frm_de_cnt", a_de, HA * VA);
          check("frm_hs_cnt", a_hs, HS * VT);
          check("frm_vs_cnt", a_vs, VS * HT);
          check("frm_ls_cnt", a_ls, VT);
        end
        a_go = 1;
        a_de = 0;
        a_hs = 0;
        a_vs = 0;
        a_ls = 0;
      end
      a_de += int'(de_a);
      a_hs += int'(!hs_a);
      a_vs += int'(!vs_a);
      a_ls += int'(ls_a);
      if (ls_a) begin
        if (a_have) check("a_ls_gap", e_a - a_last, HT);
        a_have = 1;
        a_last = e_a;
      end
    end
  always @(negedge clk)
    if (!rstn_b) b_have = 0;
    else if (ls_b) begin
      if (b_have) check("b_ls_gap", e_b - b_last, HT * 2);
      else check("b_fs_lat", {fs_b, 31'(e_b)}, {1'b1, 31'd1});
      b_have = 1;
      b_last = e_b;
    end

  initial begin
    repeat (3) @(posedge clk);
    #2 rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (2 * FR * 2 + 4 * HT * 2 + int'($urandom_range(0, 6 * HT * 2))) @(posedge clk);
    #3 rstn_b = 1'b0;
    #1;
    check("arst_de", de_b, 0);
    check("arst_rgb", rgb_b, 0);
    check("arst_hsync", hs_b, 0);
    check("arst_vsync", vs_b, 0);
    check("arst_req_valid", fb.req_valid, 0);
    check("arst_xy", {fb.x_req, fb.y_req}, 0);
    check("arst_frame_start", fs_b, 0);
    repeat (int'($urandom_range(1, 4))) @(posedge clk);
    #2 rstn_b = 1'b1;
    repeat (FR * 2 + 200) @(posedge clk);
    #3 rstn_a = 1'b0;
    rstn_b = 1'b0;
    ones = 1'b1;
    repeat (int'($urandom_range(2, 5))) @(posedge clk);
    #2 rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (FR * 2 + 100) @(posedge clk);
    #2 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Downstream scan-out stage for the double-buffered frame store. It generates VGA horizontal and vertical timing and issues pixel-coordinate requests to the frame store. It captures the returned pixel after a fixed fetch latency and drives hsync, vsync, data-enable and blanked RGB to the pins, with all outputs aligned. It also emits frame- and line-start strobes, which the frame store uses to swap buffers between frames.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIXEL_SIZE, `PIXEL_SIZE, pixel word width
- CLK_DIV, 2, clk cycles per pixel tick (≥1)
- FETCH_LAT, 1, pixel ticks from request to valid pix_in (≥1)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- pix_in  input  PIXEL_SIZE  pixel returned by frame store for the request issued FETCH_LAT ticks earlier
- x_req  output  11  requested column
- y_req  output  10  requested row
- req_valid  output  1  request is inside the active area
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  data enable (active video at pins)
- rgb  output  PIXEL_SIZE  pixel to DAC, 0 when blanked
- line_start  output  1  one-clk strobe at h_cnt=0 of every line
- frame_start  output  1  one-clk strobe at h_cnt=0, v_cnt=0

## Operation
- Tick generator: counter 0..CLK_DIV-1; tick is asserted when the counter = CLK_DIV-1. With CLK_DIV=1, tick is asserted every cycle. All state below advances only on tick.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Horizontal counter h_cnt: 0..H_TOTAL-1, wraps to 0 after H_TOTAL-1.
- Vertical counter v_cnt: increments on tick when h_cnt wraps; itself wraps to 0 after V_TOTAL-1.
- Region decode at the counter stage:
  - active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs_raw: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vs_raw: V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- Request stage, registered on tick:
  - In active: x_req=h_cnt, y_req=v_cnt, req_valid=active.
  - Outside active: x_req and y_req hold their last active value, req_valid=0.
- Delay line: active, hs_raw and vs_raw pass through a FETCH_LAT-deep shift register, advancing on tick.
- Output stage, registered on tick:
  - de = delayed active.
  - rgb = de_next ? pix_in : 0.
  - hsync = delayed hs_raw XNOR SYNC_POL.
  - vsync = delayed vs_raw XNOR SYNC_POL.
  - The rgb mux makes pix_in a don't-care when not active.
- line_start and frame_start are decoded at the counter stage, not delayed. Each is high for exactly one clk cycle: the tick cycle on which h_cnt (and, for frame_start, v_cnt) becomes 0.
- Reset (asynchronous):
  - Tick counter, h_cnt, v_cnt, x_req, y_req and the delay line clear to 0.
  - req_valid=0, de=0, rgb=0, line_start=0, frame_start=0.
  - hsync and vsync go to the inactive level (1 for SYNC_POL=0).
  - Reset mid-frame aborts the frame. After release, scanning restarts at (0,0) and the first frame_start fires on the first tick.

## Timing
- Pipeline latency from counter stage to pins is FETCH_LAT+1 ticks. Pixel (x,y) appears on rgb exactly FETCH_LAT ticks after x_req=x, y_req=y is presented.
- hsync, vsync and de share the rgb alignment; none leads or lags rgb.
- Each output holds for CLK_DIV clk cycles, changing only on the clk edge following a tick.
- Line period is H_TOTAL ticks; frame period is H_TOTAL·V_TOTAL ticks (default 420000 ticks = 840000 clk at CLK_DIV=2).
- frame_start leads the first visible pixel at the pins by FETCH_LAT+1 ticks. The frame store may swap buffers on it without tearing.

## Test plan
- Reset values: hold resetn=0, then release. Required: rgb=0, de=0, hsync=vsync=1, req_valid=0. First tick gives frame_start=1 for one clk and x_req=0, y_req=0, req_valid=1.
- Line timing (CLK_DIV=1): count clk between line_start strobes → 800. hsync is low for 96 ticks, starting FETCH_LAT+1 ticks after h_cnt=656. de is high for 640 ticks per visible line.
- Frame timing: 525 line_start per frame_start. vsync is low for lines 490–491, i.e. 1600 ticks. de=0 on lines 480–524.
- Alignment: frame-store model returns pix_in = {y_req[5:0],x_req[5:0]} after FETCH_LAT ticks. Required: rgb at the pins equals the same function of the pixel's own coordinates for every de=1 cycle, e.g. pixel (5,3) gives rgb=12'h0C5.
- Blanking: drive pix_in=all ones constantly. Required: rgb=0 whenever de=0, and rgb=all ones whenever de=1.
- Reset mid-frame at v_cnt=200 with CLK_DIV=2. Required: outputs return to reset values asynchronously. After release, frame_start occurs within 2 clk and line_start spacing is 1600 clk.
